// File: rtl/mips_pkg.sv
// Shared types and default widths for the MIPS processor memory subsystem.
// owner_t tags which requester a pending memory read belongs to.
package mips_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int STREAK_W   = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the instruction-fetch and
// data ports; data wins ties, but a streak limit keeps fetch from starving.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    owner_t              rd_owner;
    logic [STREAK_W-1:0] streak;

    // Grants are gated by reset directly so nothing is accepted while rst=0,
    // even in the part of a cycle after reset asserts asynchronously.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rst) begin
            if (d_req && !(if_req && streak == STREAK_MAX)) begin
                d_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
        if (d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (if_gnt) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_owner <= OWN_NONE;
            streak   <= '0;
        end else begin
            if (d_gnt && !d_we) begin
                rd_owner <= OWN_D;
            end else if (if_gnt) begin
                rd_owner <= OWN_IF;
            end else begin
                rd_owner <= OWN_NONE;
            end

            // Counts data wins only while fetch is actually waiting.
            if (!if_req || if_gnt) begin
                streak <= '0;
            end else if (d_gnt && streak != STREAK_MAX) begin
                streak <= streak + 1'b1;
            end
        end
    end

    assign if_rvalid = (rd_owner == OWN_IF);
    assign d_rvalid  = (rd_owner == OWN_D);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid  ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected grants and
// read data, a negedge monitor pops and compares whatever the DUT presents.
module tb_mem_port_arbiter;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: fixed initial image plus a written-word overlay.
    function automatic logic [31:0] image(input logic [31:0] a);
        case (a)
            32'h10:  return 32'h2002_0005;
            32'h14:  return 32'h8C08_0040;
            32'h18:  return 32'h2421_0001;
            32'h40:  return 32'h1234_5678;
            32'h44:  return 32'hCAFE_F00D;
            default: return 32'h0;
        endcase
    endfunction

    logic [31:0] wmem   [256];
    logic        wvalid [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                wmem[mem_addr[9:2]]   <= mem_wdata;
                wvalid[mem_addr[9:2]] <= 1'b1;
            end else begin
                mem_rdata <= (wvalid[mem_addr[9:2]] === 1'b1) ? wmem[mem_addr[9:2]]
                                                              : image(mem_addr);
            end
        end
    end

    typedef struct {
        owner_t      kind;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          cyc;
    } gnt_t;

    gnt_t        gnt_q[$];
    logic [31:0] if_q[$];
    logic [31:0] d_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc_cnt = 0;
    owner_t      exp_owner = OWN_NONE;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc_cnt, act, exp);
        end
    endtask

    // Monitor: read returns are checked against the grant the bench expected
    // one cycle earlier, then this cycle's grant is popped and compared.
    always @(negedge clk) begin
        gnt_t g;
        if (!rst) begin
            check("rst_gnt_en_we", {28'd0, if_gnt, d_gnt, mem_en, mem_we}, 32'd0);
            check("rst_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
            check("rst_rdata_or", if_rdata | d_rdata, 32'd0);
            exp_owner = OWN_NONE;
        end else begin
            check("if_rvalid", {31'd0, if_rvalid}, {31'd0, exp_owner == OWN_IF});
            check("d_rvalid", {31'd0, d_rvalid}, {31'd0, exp_owner == OWN_D});
            if (exp_owner == OWN_IF) begin
                check("if_rdata", if_rdata, (if_q.size() > 0) ? if_q.pop_front() : 32'hBAD0_BAD0);
                check("d_rdata_idle", d_rdata, 32'd0);
            end else if (exp_owner == OWN_D) begin
                check("d_rdata", d_rdata, (d_q.size() > 0) ? d_q.pop_front() : 32'hBAD0_BAD0);
                check("if_rdata_idle", if_rdata, 32'd0);
            end else begin
                check("rdata_idle", if_rdata | d_rdata, 32'd0);
            end
            exp_owner = OWN_NONE;
            if (if_gnt || d_gnt) begin
                if (gnt_q.size() == 0) begin
                    check("unexpected_gnt", {30'd0, if_gnt, d_gnt}, 32'd0);
                end else begin
                    g = gnt_q.pop_front();
                    check("gnt_kind", {30'd0, if_gnt, d_gnt},
                          (g.kind == OWN_IF) ? 32'd2 : 32'd1);
                    check("gnt_cycle", cyc_cnt, g.cyc);
                    check("mem_en", {31'd0, mem_en}, 32'd1);
                    check("mem_addr", mem_addr, g.addr);
                    check("mem_we", {31'd0, mem_we}, {31'd0, g.we});
                    check("mem_wdata", mem_wdata, g.wdata);
                    if (!g.we) exp_owner = g.kind;
                end
            end else begin
                check("idle_mem_en", {31'd0, mem_en}, 32'd0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_gnt(input owner_t k, input logic [31:0] a, input logic we,
                           input logic [31:0] wd, input int at, input logic [31:0] rd);
        gnt_t g;
        g.kind = k; g.addr = a; g.we = we; g.wdata = wd; g.cyc = at;
        gnt_q.push_back(g);
        if (!we) begin
            if (k == OWN_IF) if_q.push_back(rd);
            else             d_q.push_back(rd);
        end
    endtask

    task automatic drained(input string name);
        check({name, "_gnt_left"}, gnt_q.size(), 32'd0);
        check({name, "_rdata_left"}, if_q.size() + d_q.size(), 32'd0);
    endtask

    owner_t seq[10] = '{OWN_D, OWN_D, OWN_D, OWN_D, OWN_IF,
                        OWN_D, OWN_D, OWN_D, OWN_D, OWN_IF};

    initial begin
        gnt_t g;
        for (int i = 0; i < 256; i++) wvalid[i] = 1'b0;

        // 1: both requesting while in reset -> nothing granted.
        #1;
        if_req = 1'b1; if_addr = 32'h10;
        d_req  = 1'b1; d_addr  = 32'h40;
        tick(3);
        if_req = 1'b0; d_req = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(2);

        // 2: lone fetch.
        exp_gnt(OWN_IF, 32'h10, 1'b0, 32'h0, cyc_cnt, 32'h2002_0005);
        if_req = 1'b1; if_addr = 32'h10;
        tick(1);
        if_req = 1'b0;
        tick(2);
        drained("t2");

        // 3: simultaneous load and fetch; data first, fetch next cycle.
        exp_gnt(OWN_D,  32'h40, 1'b0, 32'h0, cyc_cnt,     32'h1234_5678);
        exp_gnt(OWN_IF, 32'h14, 1'b0, 32'h0, cyc_cnt + 1, 32'h8C08_0040);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        if_req = 1'b1; if_addr = 32'h14;
        tick(1);
        d_req = 1'b0;
        tick(1);
        if_req = 1'b0;
        tick(2);
        drained("t3");

        // 4: both held ten cycles -> D,D,D,D,IF,D,D,D,D,IF.
        for (int i = 0; i < 10; i++) begin
            if (seq[i] == OWN_IF) exp_gnt(OWN_IF, 32'h18, 1'b0, 32'h0, cyc_cnt + i, 32'h2421_0001);
            else                  exp_gnt(OWN_D,  32'h44, 1'b0, 32'h0, cyc_cnt + i, 32'hCAFE_F00D);
        end
        if_req = 1'b1; if_addr = 32'h18;
        d_req  = 1'b1; d_addr  = 32'h44; d_we = 1'b0;
        tick(10);
        if_req = 1'b0; d_req = 1'b0;
        tick(2);
        drained("t4");

        // 5: store produces no rvalid; reading it back returns the stored word.
        exp_gnt(OWN_D, 32'h80, 1'b1, 32'hDEAD_BEEF, cyc_cnt, 32'h0);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hDEAD_BEEF;
        tick(1);
        d_req = 1'b0; d_we = 1'b0; d_wdata = 32'h0;
        tick(2);
        exp_gnt(OWN_D, 32'h80, 1'b0, 32'h0, cyc_cnt, 32'hDEAD_BEEF);
        d_req = 1'b1;
        tick(1);
        d_req = 1'b0;
        tick(2);
        drained("t5");

        // 6: load granted, reset lands late in the same cycle; read is dropped,
        // held requests restart arbitration with a cleared streak.
        g.kind = OWN_D; g.addr = 32'h40; g.we = 1'b0; g.wdata = 32'h0; g.cyc = cyc_cnt;
        gnt_q.push_back(g);
        d_req = 1'b1; d_addr = 32'h40; d_we = 1'b0;
        if_req = 1'b1; if_addr = 32'h10;
        #6 rst = 1'b0;
        tick(2);
        rst = 1'b1;
        for (int i = 0; i < 4; i++)
            exp_gnt(OWN_D, 32'h40, 1'b0, 32'h0, cyc_cnt + i, 32'h1234_5678);
        exp_gnt(OWN_IF, 32'h10, 1'b0, 32'h0, cyc_cnt + 4, 32'h2002_0005);
        tick(5);
        if_req = 1'b0; d_req = 1'b0;
        tick(3);
        drained("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout cycle=%0d", cyc_cnt);
        $fatal(1, "timeout");
    end

endmodule
